// File: rtl/cdb_arbiter_pkg.sv
// cdb_arbiter_pkg: shared widths and result payload packing for the CDB arbiter
package cdb_arbiter_pkg;
  localparam int CDB_MAX_SRC = 8;
  localparam int CDB_SRC_ID_WID = 3;
  localparam int DATA_WID = 32;
  localparam int ADDR_WID = 32;
  localparam int ROB_ID_WID = 4;
  // payload is packed as {is_jump, pc, data, rob_id}
  function automatic int cdb_payload_wid(input int data_w, input int addr_w, input int rob_id_w);
    return 1 + addr_w + data_w + rob_id_w;
  endfunction
  localparam int CDB_PAYLOAD_WID = cdb_payload_wid(DATA_WID, ADDR_WID, ROB_ID_WID);
endpackage

// File: rtl/cdb_arbiter_if.sv
// cdb_arbiter_if: producer result ports and CDB broadcast lanes
interface cdb_arbiter_if
  import cdb_arbiter_pkg::*;
#(
  parameter int NUM_SRC = 2,
  parameter int NUM_BUS = 1,
  parameter int DATA_W = DATA_WID,
  parameter int ADDR_W = ADDR_WID,
  parameter int ROB_ID_W = ROB_ID_WID
);
  logic [NUM_SRC-1:0] src_valid, src_ready, src_is_jump;
  logic [NUM_SRC*ROB_ID_W-1:0] src_rob_id;
  logic [NUM_SRC*DATA_W-1:0] src_data;
  logic [NUM_SRC*ADDR_W-1:0] src_pc;
  logic [NUM_BUS-1:0] cdb_valid, cdb_is_jump;
  logic [NUM_BUS*ROB_ID_W-1:0] cdb_rob_id;
  logic [NUM_BUS*DATA_W-1:0] cdb_data;
  logic [NUM_BUS*ADDR_W-1:0] cdb_pc;
  logic [NUM_BUS*CDB_SRC_ID_WID-1:0] cdb_src;
  modport master (
    output src_valid, src_rob_id, src_data, src_is_jump, src_pc,
    input src_ready, cdb_valid, cdb_rob_id, cdb_data, cdb_is_jump, cdb_pc, cdb_src
  );
  modport slave (
    input src_valid, src_rob_id, src_data, src_is_jump, src_pc,
    output src_ready, cdb_valid, cdb_rob_id, cdb_data, cdb_is_jump, cdb_pc, cdb_src
  );
endinterface

// File: rtl/cdb_arbiter_src_fifo.sv
// cdb_src_fifo: per-producer result FIFO with head peek, count, flush and hold while !rdy
module cdb_src_fifo
  import cdb_arbiter_pkg::*;
#(
  parameter int DEPTH = 4,
  parameter int W = CDB_PAYLOAD_WID,
  localparam int AW = $clog2(DEPTH)
) (
  input  logic clk,
  input  logic rst,
  input  logic rdy,
  input  logic flush,
  input  logic push,
  input  logic pop,
  input  logic [W-1:0] din,
  output logic [W-1:0] head,
  output logic [AW:0] count
);
  logic [W-1:0] mem [DEPTH];
  logic [AW-1:0] wr_ptr, rd_ptr;
  assign head = mem[rd_ptr];
  always_ff @(posedge clk or posedge rst)
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count <= '0;
    end else if (rdy) begin
      if (flush) begin
        wr_ptr <= '0;
        rd_ptr <= '0;
        count <= '0;
      end else begin
        wr_ptr <= wr_ptr + AW'(push);
        rd_ptr <= rd_ptr + AW'(pop);
        count <= count + (AW+1)'(push) - (AW+1)'(pop);
      end
    end
  always_ff @(posedge clk)
    if (rdy && !flush && push) mem[wr_ptr] <= din;
endmodule

// File: rtl/cdb_arbiter.sv
// cdb_arbiter: buffers producer results per source and broadcasts up to NUM_BUS per cycle round-robin
module cdb_arbiter
  import cdb_arbiter_pkg::*;
#(
  parameter int NUM_SRC = 2,
  parameter int NUM_BUS = 1,
  parameter int FIFO_DEPTH = 4,
  parameter int DATA_W = DATA_WID,
  parameter int ADDR_W = ADDR_WID,
  parameter int ROB_ID_W = ROB_ID_WID
) (
  input logic clk,
  input logic rst,
  input logic rdy,
  input logic rollback,
  cdb_arbiter_if.slave bus
);
  localparam int PW = cdb_payload_wid(DATA_W, ADDR_W, ROB_ID_W);
  localparam int AW = $clog2(FIFO_DEPTH);
  localparam int SW = $clog2(NUM_SRC);
  logic active;
  logic [NUM_SRC-1:0] push_acc, nonempty, cand, grant;
  logic [PW-1:0] in_pl [NUM_SRC];
  logic [PW-1:0] head [NUM_SRC];
  logic [PW-1:0] cand_pl [NUM_SRC];
  logic [AW:0] count [NUM_SRC];
  logic [SW-1:0] rr_ptr, nxt_rr;
  int pos [NUM_SRC];
  int rank [NUM_SRC];
  int last_pos;
  logic [NUM_BUS-1:0] lane_vld, vld_q;
  logic [PW-1:0] lane_pl [NUM_BUS];
  logic [PW-1:0] pl_q [NUM_BUS];
  logic [CDB_SRC_ID_WID-1:0] lane_id [NUM_BUS];
  logic [CDB_SRC_ID_WID-1:0] id_q [NUM_BUS];

  assign active = rdy && !rollback;

  for (genvar i = 0; i < NUM_SRC; i++) begin : g_src
    assign bus.src_ready[i] = count[i] < (AW+1)'(FIFO_DEPTH);
    assign push_acc[i] = bus.src_valid[i] && bus.src_ready[i] && active;
    assign nonempty[i] = count[i] != '0;
    assign cand[i] = nonempty[i] || push_acc[i];
    assign in_pl[i] = {bus.src_is_jump[i], bus.src_pc[i*ADDR_W +: ADDR_W],
                       bus.src_data[i*DATA_W +: DATA_W], bus.src_rob_id[i*ROB_ID_W +: ROB_ID_W]};
    assign cand_pl[i] = nonempty[i] ? head[i] : in_pl[i];
    // a bypassed entry that wins a lane never enters the FIFO
    cdb_src_fifo #(.DEPTH(FIFO_DEPTH), .W(PW)) u_fifo (
      .clk(clk),
      .rst(rst),
      .rdy(rdy),
      .flush(rollback),
      .push(push_acc[i] && !(grant[i] && !nonempty[i])),
      .pop(grant[i] && nonempty[i]),
      .din(in_pl[i]),
      .head(head[i]),
      .count(count[i])
    );
  end

  // pos is each source's distance from rr_ptr; rank counts candidates scanned before it
  always_comb begin
    grant = '0;
    nxt_rr = rr_ptr;
    last_pos = -1;
    lane_vld = '0;
    lane_pl = '{default: '0};
    lane_id = '{default: '0};
    for (int i = 0; i < NUM_SRC; i++) pos[i] = (i + NUM_SRC - int'(rr_ptr)) % NUM_SRC;
    for (int i = 0; i < NUM_SRC; i++) begin
      rank[i] = 0;
      for (int j = 0; j < NUM_SRC; j++) rank[i] += (cand[j] && pos[j] < pos[i]) ? 1 : 0;
      grant[i] = active && cand[i] && rank[i] < NUM_BUS;
      if (grant[i] && pos[i] > last_pos) begin
        last_pos = pos[i];
        nxt_rr = SW'((i + 1) % NUM_SRC);
      end
    end
    for (int b = 0; b < NUM_BUS; b++)
      for (int i = 0; i < NUM_SRC; i++)
        if (grant[i] && rank[i] == b) begin
          lane_vld[b] = 1'b1;
          lane_pl[b] = cand_pl[i];
          lane_id[b] = CDB_SRC_ID_WID'(i);
        end
  end

  always_ff @(posedge clk or posedge rst)
    if (rst) begin
      rr_ptr <= '0;
      vld_q <= '0;
      pl_q <= '{default: '0};
      id_q <= '{default: '0};
    end else if (rdy) begin
      rr_ptr <= rollback ? '0 : nxt_rr;
      vld_q <= lane_vld;
      pl_q <= lane_pl;
      id_q <= lane_id;
    end

  for (genvar b = 0; b < NUM_BUS; b++) begin : g_lane
    assign bus.cdb_valid[b] = vld_q[b];
    assign {bus.cdb_is_jump[b], bus.cdb_pc[b*ADDR_W +: ADDR_W], bus.cdb_data[b*DATA_W +: DATA_W],
            bus.cdb_rob_id[b*ROB_ID_W +: ROB_ID_W]} = pl_q[b];
    assign bus.cdb_src[b*CDB_SRC_ID_WID +: CDB_SRC_ID_WID] = id_q[b];
  end

  assert property (@(posedge clk) disable iff (rst) rdy |-> (bus.src_valid & ~bus.src_ready) == '0)
    else $error("src_valid asserted while its FIFO is full");
endmodule

// File: tb/tb_cdb_arbiter.sv
// tb_cdb_arbiter: directed vectors for cdb_arbiter with a single-lane and a dual-lane instance
module tb_cdb_arbiter;
  logic clk = 1'b0, rst = 1'b1, rdy1 = 1'b1, rb1 = 1'b0, rdy2 = 1'b1, rb2 = 1'b0;
  int total = 0, bad = 0;
  always #5 clk = ~clk;

  cdb_arbiter_if #(.NUM_SRC(2), .NUM_BUS(1)) b1 ();
  cdb_arbiter_if #(.NUM_SRC(2), .NUM_BUS(2)) b2 ();
  cdb_arbiter #(.NUM_SRC(2), .NUM_BUS(1)) u1 (.clk(clk), .rst(rst), .rdy(rdy1), .rollback(rb1), .bus(b1));
  cdb_arbiter #(.NUM_SRC(2), .NUM_BUS(2)) u2 (.clk(clk), .rst(rst), .rdy(rdy2), .rollback(rb2), .bus(b2));

  typedef struct {
    logic v0; logic [3:0] r0; logic v1; logic [3:0] r1; logic rb;
    logic ev; logic [3:0] erob; logic [2:0] esrc; logic [1:0] erdy;
  } vec_t;

  function automatic vec_t mk(int v0, int r0, int v1, int r1, int rb, int ev, int er, int es, int rd);
    vec_t t;
    t.v0 = v0[0]; t.r0 = 4'(r0); t.v1 = v1[0]; t.r1 = 4'(r1); t.rb = rb[0];
    t.ev = ev[0]; t.erob = 4'(er); t.esrc = 3'(es); t.erdy = 2'(rd);
    return t;
  endfunction

  function automatic logic [31:0] dat(int s, logic [3:0] r);
    return 32'h1231 + 32'(r) + 32'h100 * 32'(s);
  endfunction
  function automatic logic [31:0] pcv(int s, logic [3:0] r);
    return 32'h8000_0000 + 32'(r) * 4 + 32'(s);
  endfunction
  function automatic logic jmp(int s, logic [3:0] r);
    return r[0] ^ s[0];
  endfunction

  task automatic drive1(input logic v0, input logic [3:0] r0, input logic v1, input logic [3:0] r1);
    b1.src_valid = {v1, v0};
    b1.src_rob_id = {r1, r0};
    b1.src_data = {dat(1, r1), dat(0, r0)};
    b1.src_pc = {pcv(1, r1), pcv(0, r0)};
    b1.src_is_jump = {jmp(1, r1), jmp(0, r0)};
  endtask

  task automatic drive2(input logic v0, input logic [3:0] r0, input logic v1, input logic [3:0] r1);
    b2.src_valid = {v1, v0};
    b2.src_rob_id = {r1, r0};
    b2.src_data = {dat(1, r1), dat(0, r0)};
    b2.src_pc = {pcv(1, r1), pcv(0, r0)};
    b2.src_is_jump = {jmp(1, r1), jmp(0, r0)};
  endtask

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic lane_chk(input string tag, input logic [3:0] rob, input logic [2:0] src,
                          input logic [31:0] d, input logic [31:0] p, input logic j,
                          input logic [3:0] er, input int es);
    chk({tag, "_rob"}, 64'(rob), 64'(er));
    chk({tag, "_src"}, 64'(src), 64'(es));
    chk({tag, "_data"}, 64'(d), 64'(dat(es, er)));
    chk({tag, "_pc"}, 64'(p), 64'(pcv(es, er)));
    chk({tag, "_jump"}, 64'(j), 64'(jmp(es, er)));
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic lane2_chk(input string tag, input int lane, input logic [3:0] er, input int es);
    if (lane == 0)
      lane_chk(tag, b2.cdb_rob_id[3:0], b2.cdb_src[2:0], b2.cdb_data[31:0], b2.cdb_pc[31:0],
               b2.cdb_is_jump[0], er, es);
    else
      lane_chk(tag, b2.cdb_rob_id[7:4], b2.cdb_src[5:3], b2.cdb_data[63:32], b2.cdb_pc[63:32],
               b2.cdb_is_jump[1], er, es);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not reach the end");
    $fatal(1);
  end

  initial begin
    vec_t tbl [16];
    int sent [2];
    int got [2];
    int s;
    logic saw_full, v0, v1;
    drive1(0, 0, 0, 0);
    drive2(0, 0, 0, 0);
    repeat (2) @(posedge clk);
    #1;
    chk("rst_valid1", 64'(b1.cdb_valid), 64'(0));
    chk("rst_ready1", 64'(b1.src_ready), 64'(2'b11));
    chk("rst_valid2", 64'(b2.cdb_valid), 64'(0));
    rst = 1'b0;

    tbl[0]  = mk(0, 0, 0, 0, 0, 0, 0, 0, 3);
    tbl[1]  = mk(1, 3, 0, 0, 0, 1, 3, 0, 3);
    tbl[2]  = mk(0, 0, 0, 0, 0, 0, 0, 0, 3);
    tbl[3]  = mk(0, 0, 1, 5, 0, 1, 5, 1, 3);
    tbl[4]  = mk(1, 1, 1, 2, 0, 1, 1, 0, 3);
    tbl[5]  = mk(0, 0, 0, 0, 0, 1, 2, 1, 3);
    tbl[6]  = mk(1, 1, 1, 2, 0, 1, 1, 0, 3);
    tbl[7]  = mk(0, 0, 0, 0, 0, 1, 2, 1, 3);
    tbl[8]  = mk(0, 0, 0, 0, 0, 0, 0, 0, 3);
    tbl[9]  = mk(1, 10, 1, 11, 0, 1, 10, 0, 3);
    tbl[10] = mk(1, 12, 1, 13, 0, 1, 11, 1, 3);
    tbl[11] = mk(1, 14, 1, 15, 0, 1, 12, 0, 3);
    tbl[12] = mk(1, 6, 1, 7, 0, 1, 13, 1, 3);
    tbl[13] = mk(1, 8, 0, 0, 1, 0, 0, 0, 3);
    tbl[14] = mk(0, 0, 0, 0, 0, 0, 0, 0, 3);
    tbl[15] = mk(0, 0, 0, 0, 0, 0, 0, 0, 3);
    for (int i = 0; i < 16; i++) begin
      drive1(tbl[i].v0, tbl[i].r0, tbl[i].v1, tbl[i].r1);
      rb1 = tbl[i].rb;
      step();
      chk($sformatf("vec%0d_valid", i), 64'(b1.cdb_valid), 64'(tbl[i].ev));
      chk($sformatf("vec%0d_ready", i), 64'(b1.src_ready), 64'(tbl[i].erdy));
      if (tbl[i].ev)
        lane_chk($sformatf("vec%0d", i), b1.cdb_rob_id, b1.cdb_src, b1.cdb_data, b1.cdb_pc,
                 b1.cdb_is_jump, tbl[i].erob, int'(tbl[i].esrc));
    end
    rb1 = 1'b0;

    sent = '{0, 0};
    got = '{0, 0};
    saw_full = 1'b0;
    for (int cyc = 0; cyc < 200 && (got[0] < 10 || got[1] < 10); cyc++) begin
      v0 = sent[0] < 10 && b1.src_ready[0];
      v1 = sent[1] < 10 && b1.src_ready[1];
      drive1(v0, 4'(sent[0]), v1, 4'(sent[1]));
      step();
      if (v0) sent[0]++;
      if (v1) sent[1]++;
      if (!b1.src_ready[1]) saw_full = 1'b1;
      if (b1.cdb_valid[0]) begin
        s = int'(b1.cdb_src);
        if (s > 1) chk("bp_src_range", 64'(s), 64'(0));
        else begin
          chk($sformatf("bp_tag_src%0d", s), 64'(b1.cdb_rob_id), 64'(got[s]));
          got[s]++;
        end
      end
    end
    drive1(0, 0, 0, 0);
    chk("bp_count_src0", 64'(got[0]), 64'(10));
    chk("bp_count_src1", 64'(got[1]), 64'(10));
    chk("bp_src1_full_seen", 64'(saw_full), 64'(1));

    drive2(1, 1, 1, 2);
    step();
    chk("dual_valid", 64'(b2.cdb_valid), 64'(2'b11));
    lane2_chk("dual_l0", 0, 1, 0);
    lane2_chk("dual_l1", 1, 2, 1);
    drive2(1, 3, 1, 4);
    rdy2 = 1'b0;
    for (int k = 0; k < 3; k++) begin
      rb2 = (k == 2);
      step();
      chk($sformatf("hold%0d_valid", k), 64'(b2.cdb_valid), 64'(2'b11));
      lane2_chk($sformatf("hold%0d_l0", k), 0, 1, 0);
      lane2_chk($sformatf("hold%0d_l1", k), 1, 2, 1);
    end
    rb2 = 1'b0;
    rdy2 = 1'b1;
    step();
    chk("resume_valid", 64'(b2.cdb_valid), 64'(2'b11));
    lane2_chk("resume_l0", 0, 3, 0);
    lane2_chk("resume_l1", 1, 4, 1);
    drive2(1, 5, 0, 0);
    step();
    chk("single_valid", 64'(b2.cdb_valid), 64'(2'b01));
    lane2_chk("single_l0", 0, 5, 0);
    drive2(1, 6, 1, 7);
    step();
    chk("rot_valid", 64'(b2.cdb_valid), 64'(2'b11));
    lane2_chk("rot_l0", 0, 7, 1);
    lane2_chk("rot_l1", 1, 6, 0);
    drive2(0, 0, 0, 0);
    step();
    chk("idle2_valid", 64'(b2.cdb_valid), 64'(0));

    drive1(1, 1, 1, 2);
    step();
    drive1(1, 3, 1, 4);
    step();
    drive1(1, 5, 1, 6);
    step();
    drive1(0, 0, 0, 0);
    chk("pre_rst_valid", 64'(b1.cdb_valid), 64'(1));
    #3 rst = 1'b1;
    #1;
    chk("mid_rst_valid1", 64'(b1.cdb_valid), 64'(0));
    chk("mid_rst_ready1", 64'(b1.src_ready), 64'(2'b11));
    chk("mid_rst_ready2", 64'(b2.src_ready), 64'(2'b11));
    #2 rst = 1'b0;
    for (int k = 0; k < 6; k++) begin
      step();
      chk($sformatf("post_rst%0d_valid", k), 64'(b1.cdb_valid), 64'(0));
    end
    drive1(1, 9, 1, 10);
    step();
    chk("post_rst_grant_valid", 64'(b1.cdb_valid), 64'(1));
    lane_chk("post_rst_grant", b1.cdb_rob_id, b1.cdb_src, b1.cdb_data, b1.cdb_pc, b1.cdb_is_jump, 9, 0);
    drive1(0, 0, 0, 0);
    step();
    lane_chk("post_rst_second", b1.cdb_rob_id, b1.cdb_src, b1.cdb_data, b1.cdb_pc, b1.cdb_is_jump, 10, 1);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
